// File: rtl/rom_burst_arbiter_pkg.sv
// Shared types and constants for the ROM burst arbiter.
package rom_arb_pkg;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned ROM_WIDTH = 32;
  localparam int unsigned ROM_DEPTH = 8;
  localparam int unsigned ROM_LEN_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic owner_t;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Requester-side bus: two burst request channels and a shared response channel.
interface rom_burst_arbiter_if #(
  parameter int unsigned WIDTH = rom_arb_pkg::ROM_WIDTH,
  parameter int unsigned DEPTH = rom_arb_pkg::ROM_DEPTH,
  parameter int unsigned LEN_W = rom_arb_pkg::ROM_LEN_W
);

  logic             req0;
  logic             req1;
  logic [DEPTH-1:0] addr0;
  logic [DEPTH-1:0] addr1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic             rlast;
  logic [WIDTH-1:0] rdata;
  logic             busy;

  modport master (
    output req0, req1, addr0, addr1, len0, len1,
    input  gnt0, gnt1, rvalid0, rvalid1, rlast, rdata, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1,
    output gnt0, gnt1, rvalid0, rvalid1, rlast, rdata, busy
  );

endinterface

// File: rtl/rom_burst_arbiter_rr_pick.sv
// Two-way round-robin choice: rr_ptr breaks ties, a lone requester always wins.
module rom_rr_pick
  import rom_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  owner_t          rr_ptr,
  output logic [NREQ-1:0] gnt
);

  // Pass a single request through; on contention grant the pointed-to requester.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one synchronous ROM read port between two burst requesters.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ROM_WIDTH,
  parameter int unsigned DEPTH = ROM_DEPTH,
  parameter int unsigned LEN_W = ROM_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  rom_burst_arbiter_if.slave  bus,
  output logic                rom_re,
  output logic [DEPTH-1:0]    rom_addr,
  input  logic [WIDTH-1:0]    rom_dataout
);

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] cur_addr;
  logic [LEN_W-1:0] remaining;
  owner_t           owner;
  owner_t           rr_ptr;
  owner_t           winner;
  logic [NREQ-1:0]  pick;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  rvalid;
  logic             accept;
  logic             last_beat;
  logic             busy;
  logic             rlast;

  rom_rr_pick u_pick (
    .req    ({bus.req1, bus.req0}),
    .rr_ptr (rr_ptr),
    .gnt    (pick)
  );

  assign winner = owner_t'(pick[1]);
  assign accept = (state == IDLE) && (|pick);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on any request, leave BURST after the final beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pick) state_nxt = BURST;
      BURST:   if (remaining == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; grants are held off while reset is asserted.
  always_comb begin
    gnt       = '0;
    rom_re    = 1'b0;
    rom_addr  = '0;
    busy      = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) gnt = pick;
      end
      BURST: begin
        rom_re    = 1'b1;
        rom_addr  = cur_addr;
        busy      = 1'b1;
        last_beat = (remaining == '0);
      end
      default: ;
    endcase
  end

  // Burst capture on accept, then address/length stepping once per beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
    end else if (accept) begin
      cur_addr  <= winner ? bus.addr1 : bus.addr0;
      remaining <= winner ? bus.len1 : bus.len0;
      owner     <= winner;
      rr_ptr    <= ~winner;
    end else if (state == BURST) begin
      cur_addr  <= DEPTH'(cur_addr + 1'b1);
      remaining <= LEN_W'(remaining - 1'b1);
    end
  end

  // Response pipeline: one cycle behind the ROM read enable, steered to the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= '0;
      rlast  <= 1'b0;
    end else begin
      rvalid <= rom_re ? (owner ? 2'b10 : 2'b01) : 2'b00;
      rlast  <= last_beat;
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rlast   = rlast;
  assign bus.busy    = busy;
  assign bus.rdata   = (|rvalid) ? rom_dataout : '0;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Testbench for rom_burst_arbiter: directed burst table, hand sequences and random traffic.
module tb_rom_burst_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int          RING  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_re;
  logic [7:0]  rom_addr;
  logic [31:0] rom_dataout;

  rom_burst_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  rom_burst_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rom_re      (rom_re),
    .rom_addr    (rom_addr),
    .rom_dataout (rom_dataout)
  );

  always #10 clk = ~clk;

  // Known ROM image as a function of the address.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {a ^ 8'hC3, ~a, a, a + 8'h5A};
  endfunction

  // Synchronous-read ROM: data one cycle after the read enable.
  always @(posedge clk) if (rom_re) rom_dataout <= rom_word(rom_addr);

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: each grant schedules its read beats and response beats into a
  // cycle-indexed table; the arbiter is free again len+2 cycles after the grant.
  logic        m_re   [RING];
  logic [7:0]  m_addr [RING];
  logic [1:0]  m_rv   [RING];
  logic [31:0] m_data [RING];
  logic        m_last [RING];
  logic        m_ptr   = 1'b0;
  int          free_at = 0;
  int cnt_rv0, cnt_rv1, cnt_last, cnt_busy;

  always @(negedge clk) begin : model
    int         s;
    logic       w;
    logic [7:0] a;
    int         l;
    logic [1:0] eg;
    s = cyc % RING;
    if (bus.rvalid0) cnt_rv0++;
    if (bus.rvalid1) cnt_rv1++;
    if (bus.rlast)   cnt_last++;
    if (bus.busy)    cnt_busy++;
    if (rst) begin
      for (int i = 0; i < RING; i++) begin
        m_re[i] = 1'b0; m_addr[i] = '0; m_rv[i] = '0; m_data[i] = '0; m_last[i] = 1'b0;
      end
      m_ptr   = 1'b0;
      free_at = cyc + 1;
      check("reset_outputs", {bus.gnt0, bus.gnt1, rom_re, rom_addr, bus.busy,
                              bus.rvalid0, bus.rvalid1, bus.rlast, bus.rdata}, '0);
    end else begin
      eg = 2'b00;
      if (cyc >= free_at && (bus.req0 || bus.req1)) begin
        w  = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
        eg = w ? 2'b10 : 2'b01;
        a  = w ? bus.addr1 : bus.addr0;
        l  = int'(w ? bus.len1 : bus.len0);
        for (int i = 0; i <= l; i++) begin
          m_re  [(cyc + 1 + i) % RING] = 1'b1;
          m_addr[(cyc + 1 + i) % RING] = 8'(int'(a) + i);
          m_rv  [(cyc + 2 + i) % RING] = eg;
          m_data[(cyc + 2 + i) % RING] = rom_word(8'(int'(a) + i));
          m_last[(cyc + 2 + i) % RING] = (i == l);
        end
        free_at = cyc + l + 2;
        m_ptr   = ~w;
      end
      check("gnt", {bus.gnt1, bus.gnt0}, eg);
      check("rom_re", rom_re, m_re[s]);
      check("busy", bus.busy, m_re[s]);
      if (m_re[s]) check("rom_addr", rom_addr, m_addr[s]);
      check("rvalid", {bus.rvalid1, bus.rvalid0}, m_rv[s]);
      check("rlast", bus.rlast, m_last[s]);
      if (m_rv[s] != 2'b00) check("rdata", bus.rdata, m_data[s]);
    end
    m_re[s] = 1'b0; m_rv[s] = '0; m_last[s] = 1'b0;
    cyc++;
  end

  typedef struct {
    string      name;
    logic       do_rst;
    logic       r0;
    logic [7:0] a0;
    logic [3:0] l0;
    logic       r1;
    logic [7:0] a1;
    logic [3:0] l1;
    int         exp_first;
    int         exp_rv0;
    int         exp_rv1;
    int         exp_last;
    int         exp_busy;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_rv0 = 0; cnt_rv1 = 0; cnt_last = 0; cnt_busy = 0;
  endtask

  // Wait (bounded) until no burst or response is in flight.
  task automatic wait_idle(input string name);
    logic done;
    int   guard;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      done = !bus.busy && !bus.rvalid0 && !bus.rvalid1;
      if (!done) step();
      guard++;
    end
    check({name, "_idle"}, done, 1'b1);
    step();
  endtask

  // Present the requests of one record, hold each until granted, then compare totals.
  task automatic run_vec(input vec_t v);
    int   first;
    int   guard;
    logic p0, p1;
    if (v.do_rst) begin
      rst = 1'b1; step(); step(); rst = 1'b0;
    end
    clear_counts();
    bus.req0 = v.r0; bus.addr0 = v.a0; bus.len0 = v.l0;
    bus.req1 = v.r1; bus.addr1 = v.a1; bus.len1 = v.l1;
    p0 = v.r0; p1 = v.r1; first = -1; guard = 0;
    while ((p0 || p1) && guard < 100) begin
      @(negedge clk);
      if (bus.gnt0 && p0) begin if (first < 0) first = 0; p0 = 1'b0; end
      if (bus.gnt1 && p1) begin if (first < 0) first = 1; p1 = 1'b0; end
      step();
      if (!p0) bus.req0 = 1'b0;
      if (!p1) bus.req1 = 1'b0;
      guard++;
    end
    check({v.name, "_granted"}, {p1, p0}, 2'b00);
    wait_idle(v.name);
    check({v.name, "_first"}, 64'(first), 64'(v.exp_first));
    check({v.name, "_rv0"},   64'(cnt_rv0), 64'(v.exp_rv0));
    check({v.name, "_rv1"},   64'(cnt_rv1), 64'(v.exp_rv1));
    check({v.name, "_last"},  64'(cnt_last), 64'(v.exp_last));
    check({v.name, "_busy"},  64'(cnt_busy), 64'(v.exp_busy));
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   seq[8];
    int   n;
    int   guard;
    logic g0, g1;

    vecs[0] = '{"single",  1'b0, 1'b1, 8'h10, 4'd3, 1'b0, 8'h00, 4'd0, 0, 4, 0, 1, 4};
    vecs[1] = '{"contend", 1'b1, 1'b1, 8'h20, 4'd1, 1'b1, 8'h30, 4'd1, 0, 2, 2, 2, 4};
    vecs[2] = '{"wrap",    1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hFE, 4'd3, 1, 0, 4, 1, 4};
    vecs[3] = '{"maxlen",  1'b0, 1'b1, 8'hF8, 4'hF, 1'b0, 8'h00, 4'd0, 0, 16, 0, 1, 16};
    vecs[4] = '{"tie_ptr", 1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 8'hFF, 4'd0, 1, 1, 1, 2, 2};
    vecs[5] = '{"solo1",   1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'h80, 4'd2, 1, 0, 3, 1, 3};
    vecs[6] = '{"mixed",   1'b0, 1'b1, 8'h7F, 4'd2, 1'b1, 8'h3C, 4'd0, 0, 3, 1, 2, 4};
    vecs[7] = '{"top_one", 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 8'h00, 4'd0, 0, 1, 0, 1, 1};

    bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0;
    clear_counts();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of an 8-beat burst, on the third response beat.
    clear_counts();
    bus.req0 = 1'b1; bus.addr0 = 8'h40; bus.len0 = 4'd7;
    g0 = 1'b0; guard = 0;
    while (!g0 && guard < 20) begin
      @(negedge clk);
      g0 = bus.gnt0;
      step();
      guard++;
    end
    bus.req0 = 1'b0;
    check("midrst_gnt", g0, 1'b1);
    step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_beats_before", 64'(cnt_rv0), 64'd2);
    check("midrst_rom_re", rom_re, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_rvalid0", bus.rvalid0, 1'b0);
    check("midrst_rlast", bus.rlast, 1'b0);
    step();
    rst = 1'b0;
    clear_counts();
    repeat (12) step();
    check("midrst_no_residual", 64'(cnt_rv0 + cnt_rv1 + cnt_last), 64'd0);
    check("midrst_no_busy", 64'(cnt_busy), 64'd0);
    v = '{"post_rst", 1'b0, 1'b1, 8'h05, 4'd1, 1'b1, 8'h06, 4'd0, 0, 2, 1, 2, 3};
    run_vec(v);

    // Fairness: both held high with single-beat bursts.
    rst = 1'b1; step(); rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 8'hA0; bus.len0 = 4'd0;
    bus.req1 = 1'b1; bus.addr1 = 8'hB0; bus.len1 = 4'd0;
    n = 0; guard = 0;
    while (n < 8 && guard < 60) begin
      @(negedge clk);
      if (bus.gnt0) begin seq[n] = 0; n++; end
      else if (bus.gnt1) begin seq[n] = 1; n++; end
      step();
      guard++;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("fair_count", 64'(n), 64'd8);
    for (int i = 0; i < n; i++) check("fair_order", 64'(seq[i]), 64'(i % 2));
    wait_idle("fair");

    // Random traffic, including requests withdrawn before their grant.
    g0 = 1'b0; g1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g0 = bus.gnt0; g1 = bus.gnt1;
      step();
      if (bus.req0) begin
        if (g0 || $urandom_range(0, 39) == 0) bus.req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.req0  = 1'b1;
        bus.addr0 = 8'($urandom);
        bus.len0  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      end
      if (bus.req1) begin
        if (g1 || $urandom_range(0, 39) == 0) bus.req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.req1  = 1'b1;
        bus.addr1 = 8'($urandom);
        bus.len1  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
